// File: rtl/map_rom_arbiter_if.sv
// Query/result channel between the game-logic FSM and the map ROM arbiter.
// The master pushes (x, y) queries and receives one in-order result pulse per query.
interface map_rom_arbiter_if;
  logic       q_valid;
  logic       q_ready;
  logic [9:0] q_x;
  logic [9:0] q_y;
  logic       r_valid;
  logic [3:0] r_index;
  logic       r_oob;

  modport master (
    output q_valid, q_x, q_y,
    input  q_ready, r_valid, r_index, r_oob
  );

  modport slave (
    input  q_valid, q_x, q_y,
    output q_ready, r_valid, r_index, r_oob
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// Shares the single-port map ROM between the pixel path (active display) and queued game-logic
// queries (blanking). Pixel: 2 edges from DrawX/DrawY; query: 3 edges best case; q_ready = FIFO not full.
module map_rom_arbiter #(
  parameter int QDEPTH = 4,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int AW     = 20
) (
  input  logic                vga_clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  output logic [AW-1:0]       rom_address,
  input  logic [3:0]          rom_q,
  output logic [3:0]          pix_index,
  output logic                pix_valid,
  map_rom_arbiter_if.slave    qif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // The registered state is the owner of the read currently in flight inside the ROM.
  typedef enum logic [1:0] {TAG_NONE, TAG_PIXEL, TAG_QUERY, TAG_OOB} tag_e;

  tag_e          tag_q, tag_d;
  logic [9:0]    qx_mem [QDEPTH];
  logic [9:0]    qy_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop, head_inb;
  logic [9:0]    head_x, head_y;
  logic [AW-1:0] pix_addr, head_addr;
  logic [3:0]    pix_index_q, r_index_q;
  logic          pix_valid_q, r_valid_q, r_oob_q;

  function automatic logic [AW-1:0] map_addr(input logic [9:0] x, input logic [9:0] y);
    logic [AW-1:0] yw;
    yw = AW'(y);
    return AW'(x) + (yw << 9) + (yw << 7);
  endfunction

  assign full        = (count_q == CW'(QDEPTH));
  assign empty       = (count_q == '0);
  assign qif.q_ready = !full;
  assign push        = qif.q_valid && !full;
  assign pop         = !blank && !empty;
  assign count_d     = count_q + CW'(push) - CW'(pop);

  assign head_x    = qx_mem[rd_ptr_q];
  assign head_y    = qy_mem[rd_ptr_q];
  assign head_inb  = (32'(head_x) < H_RES) && (32'(head_y) < V_RES);
  assign pix_addr  = map_addr(DrawX, DrawY);
  assign head_addr = map_addr(head_x, head_y);

  always_comb begin
    tag_d       = TAG_NONE;
    rom_address = '0;
    if (blank) begin
      tag_d       = TAG_PIXEL;
      rom_address = pix_addr;
    end else if (pop) begin
      if (head_inb) begin
        tag_d       = TAG_QUERY;
        rom_address = head_addr;
      end else begin
        tag_d = TAG_OOB;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) tag_q <= TAG_NONE;
    else       tag_q <= tag_d;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push && !reset) begin
      qx_mem[wr_ptr_q] <= qif.q_x;
      qy_mem[wr_ptr_q] <= qif.q_y;
    end
  end

  // Out-of-bounds entries complete in their FIFO slot without touching the ROM.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
      r_index_q   <= '0;
      r_valid_q   <= 1'b0;
      r_oob_q     <= 1'b0;
    end else begin
      pix_valid_q <= (tag_q == TAG_PIXEL);
      r_valid_q   <= (tag_q == TAG_QUERY) || (tag_q == TAG_OOB);
      case (tag_q)
        TAG_PIXEL: pix_index_q <= rom_q;
        TAG_QUERY: begin
          r_index_q <= rom_q;
          r_oob_q   <= 1'b0;
        end
        TAG_OOB: begin
          r_index_q <= '0;
          r_oob_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pix_index   = pix_index_q;
  assign pix_valid   = pix_valid_q;
  assign qif.r_index = r_index_q;
  assign qif.r_valid = r_valid_q;
  assign qif.r_oob   = r_oob_q;

endmodule
